wide_move_sequencer: RTL and testbench

WIDE_MOVE_SEQUENCER -- requirements
Module: wide_move_sequencer

---
 rtl/wide_move_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_wide_move_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_move_sequencer.sv
// Wide-move (MOVZ/MOVK/MOVN) control sequencer: expands one instruction into 1-2 datapath control words.
// Optional MOVN execution is enabled by defining WIDE_MOVE_MOVN_EN; otherwise opc=00 is rejected as illegal.
module wide_move_sequencer #(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_HW     = DATA_WIDTH / 16
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [31:0]           instruction,
   input  logic                  ready,
   output logic [30:0]           controlWord,
   output logic [DATA_WIDTH-1:0] K,
   output logic                  valid,
   output logic                  busy,
   output logic                  done,
   output logic                  illegal
);

   typedef enum logic [1:0] {IDLE, STEP1, STEP2, FINISH} state_t;

   localparam int         NUM_LANES = DATA_WIDTH / 16;
   localparam logic [2:0] NUM_HW_L  = 3'(NUM_HW);
   localparam logic [1:0] OPC_MOVZ  = 2'b10;
   localparam logic [1:0] OPC_MOVK  = 2'b11;
`ifdef WIDE_MOVE_MOVN_EN
   localparam logic [1:0] OPC_MOVN  = 2'b00;
`endif
   localparam logic [1:0] PSEL_HOLD = 2'b00;
   localparam logic [1:0] PSEL_INC4 = 2'b01;
   localparam logic [4:0] FSEL_AND  = 5'b00000;
   localparam logic [4:0] FSEL_OR   = 5'b00100;
   localparam logic [4:0] XZR       = 5'd31;
   // {regW, ramW, EN_MEM, EN_ALU, EN_B, EN_PC, Bsel, PCsel, SL}
   localparam logic [8:0] CTRL_FLAGS = 9'b1_0_0_1_0_0_1_0_0;

   state_t      state_q, state_d;
   logic [1:0]  opc_q, opc_d;
   logic [1:0]  hw_q, hw_d;
   logic [15:0] imm_q, imm_d;
   logic [4:0]  rd_q, rd_d;
   logic        illegal_q, illegal_d;

   logic [1:0]  in_opc;
   logic [1:0]  in_hw;
   logic        opc_ok;
   logic        hw_ok;
   logic        unused_insn_bits;

   logic [NUM_LANES-1:0]  lane_hit;
   logic [DATA_WIDTH-1:0] imm_shift;
   logic [DATA_WIDTH-1:0] lane_mask;

   logic [1:0]            cw_psel;
   logic [4:0]            cw_sa;
   logic [4:0]            cw_fsel;
   logic [DATA_WIDTH-1:0] k_val;

   assign in_opc           = instruction[30:29];
   assign in_hw            = instruction[22:21];
   assign unused_insn_bits = ^{instruction[31], instruction[28:23]};
   assign hw_ok            = ({1'b0, in_hw} < NUM_HW_L);

   always_comb begin
      opc_ok = 1'b0;
      case (in_opc)
         OPC_MOVZ, OPC_MOVK: opc_ok = 1'b1;
`ifdef WIDE_MOVE_MOVN_EN
         OPC_MOVN:           opc_ok = 1'b1;
`endif
         default:            opc_ok = 1'b0;
      endcase
   end

   // Lane-wise shift: only the selected 16-bit lane carries imm16 / the mask.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         assign lane_hit[gi]             = (hw_q == 2'(gi));
         assign imm_shift[16*gi +: 16]   = lane_hit[gi] ? imm_q : 16'h0000;
         assign lane_mask[16*gi +: 16]   = {16{lane_hit[gi]}};
      end
   endgenerate

   always_comb begin
      state_d   = state_q;
      opc_d     = opc_q;
      hw_d      = hw_q;
      imm_d     = imm_q;
      rd_d      = rd_q;
      illegal_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (opc_ok && hw_ok) begin
                  opc_d   = in_opc;
                  hw_d    = in_hw;
                  imm_d   = instruction[20:5];
                  rd_d    = instruction[4:0];
                  state_d = STEP1;
               end else begin
                  illegal_d = 1'b1;
               end
            end
         end
         STEP1: begin
            if (ready) begin
               state_d = (opc_q == OPC_MOVK) ? STEP2 : FINISH;
            end
         end
         STEP2: begin
            if (ready) begin
               state_d = FINISH;
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         opc_q     <= 2'b00;
         hw_q      <= 2'b00;
         imm_q     <= 16'h0000;
         rd_q      <= 5'd0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         opc_q     <= opc_d;
         hw_q      <= hw_d;
         imm_q     <= imm_d;
         rd_q      <= rd_d;
         illegal_q <= illegal_d;
      end
   end

   assign valid   = (state_q == STEP1) || (state_q == STEP2);
   assign busy    = (state_q != IDLE);
   assign done    = (state_q == FINISH);
   assign illegal = illegal_q;

   // MOVK clears the target lane first (AND ~M), then ORs the new lane in.
   always_comb begin
      cw_psel = PSEL_HOLD;
      cw_sa   = 5'd0;
      cw_fsel = FSEL_AND;
      k_val   = '0;
      case (state_q)
         STEP1: begin
            if (opc_q == OPC_MOVK) begin
               cw_psel = PSEL_HOLD;
               cw_sa   = rd_q;
               cw_fsel = FSEL_AND;
               k_val   = ~lane_mask;
            end else begin
               cw_psel = PSEL_INC4;
               cw_sa   = XZR;
               cw_fsel = FSEL_OR;
`ifdef WIDE_MOVE_MOVN_EN
               k_val   = (opc_q == OPC_MOVN) ? ~imm_shift : imm_shift;
`else
               k_val   = imm_shift;
`endif
            end
         end
         STEP2: begin
            cw_psel = PSEL_INC4;
            cw_sa   = rd_q;
            cw_fsel = FSEL_OR;
            k_val   = imm_shift;
         end
         default: ;
      endcase
   end

   always_comb begin
      controlWord = '0;
      K           = '0;
      if (valid) begin
         controlWord = {cw_psel, rd_q, cw_sa, XZR, cw_fsel, CTRL_FLAGS};
         K           = k_val;
      end
   end

endmodule

// File: tb/tb_wide_move_sequencer.sv
// Scoreboard bench for wide_move_sequencer: 64-bit instance for sequencing, 32-bit instance for lane limits.
module tb_wide_move_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, start, ready;
   logic [31:0] instruction;
   logic [30:0] cw;
   logic [63:0] k;
   logic        valid, busy, done, illegal;

   logic        s_start;
   logic [31:0] s_instr;
   logic [30:0] s_cw;
   logic [31:0] s_k;
   logic        s_valid, s_busy, s_done, s_illegal;

   wide_move_sequencer dut (
      .clock(clk), .reset_n(reset_n), .start(start), .instruction(instruction),
      .ready(ready), .controlWord(cw), .K(k), .valid(valid), .busy(busy),
      .done(done), .illegal(illegal)
   );

   wide_move_sequencer #(.DATA_WIDTH(32)) dut32 (
      .clock(clk), .reset_n(reset_n), .start(s_start), .instruction(s_instr),
      .ready(1'b1), .controlWord(s_cw), .K(s_k), .valid(s_valid), .busy(s_busy),
      .done(s_done), .illegal(s_illegal)
   );

   typedef struct packed {
      logic [30:0] cw;
      logic [63:0] k;
   } word_t;

   word_t exp_q[$];
   int checks = 0;
   int errors = 0;

   function automatic word_t mk(input logic [1:0] psel, input logic [4:0] da,
                                input logic [4:0] sa, input logic [4:0] fsel,
                                input logic [63:0] kv);
      word_t w;
      w.cw = {psel, da, sa, 5'd31, fsel, 9'b100100100};
      w.k  = kv;
      return w;
   endfunction

   function automatic void model_push(input logic [31:0] ins);
      logic [1:0]  opc;
      logic [15:0] imm;
      logic [4:0]  rd;
      int          sh;
      logic [63:0] v, m;
      opc = ins[30:29];
      imm = ins[20:5];
      rd  = ins[4:0];
      sh  = 16 * int'(ins[22:21]);
      v   = {48'd0, imm} << sh;
      m   = 64'h0000_0000_0000_FFFF << sh;
      case (opc)
         2'b10: exp_q.push_back(mk(2'b01, rd, 5'd31, 5'b00100, v));
         2'b00: exp_q.push_back(mk(2'b01, rd, 5'd31, 5'b00100, ~v));
         2'b11: begin
            exp_q.push_back(mk(2'b00, rd, rd, 5'b00000, ~m));
            exp_q.push_back(mk(2'b01, rd, rd, 5'b00100, v));
         end
         default: ;
      endcase
   endfunction

   // Issues one instruction and consumes words against the scoreboard; stall = ready-low cycles per word.
   task automatic run_seq(input string name, input logic [31:0] ins, input int stall, input bit poke);
      int  stall_left;
      bit  finished;
      start = 1'b1;
      instruction = ins;
      ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      instruction = $urandom;
      checks++;
      if (valid !== 1'b1 || illegal !== 1'b0) begin
         errors++;
         $display("FAIL %s_first_valid: got valid=%b illegal=%b, expected valid=1 illegal=0", name, valid, illegal);
      end
      stall_left = stall;
      finished = 1'b0;
      for (int cyc = 0; cyc < 60 && !finished; cyc++) begin
         start = 1'b0;
         ready = 1'b0;
         if (poke && cyc == 0) begin
            start = 1'b1;
            instruction = 32'hD280_0000;
         end
         if (valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL %s_extra_word: got cw=%h k=%h, expected no word", name, cw, k);
            end else if ({cw, k} !== exp_q[0]) begin
               errors++;
               $display("FAIL %s_word: got cw=%h k=%h, expected cw=%h k=%h",
                        name, cw, k, exp_q[0].cw, exp_q[0].k);
            end
            if (stall_left > 0) begin
               stall_left--;
            end else begin
               ready = 1'b1;
               if (exp_q.size() != 0) void'(exp_q.pop_front());
               stall_left = stall;
            end
         end else begin
            checks++;
            if (done !== 1'b1 || cw !== 31'd0 || k !== 64'd0 || busy !== 1'b1) begin
               errors++;
               $display("FAIL %s_done_cycle: got done=%b busy=%b cw=%h k=%h, expected done=1 busy=1 cw=0 k=0",
                        name, done, busy, cw, k);
            end
            finished = 1'b1;
         end
         @(negedge clk);
      end
      start = 1'b0;
      ready = 1'b0;
      checks++;
      if (!finished) begin
         errors++;
         $display("FAIL %s_timeout: got no done within 60 cycles, expected done", name);
      end
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_after_done: got done=%b busy=%b valid=%b, expected 0 0 0", name, done, busy, valid);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_leftover: got %0d unissued words, expected 0", name, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      start = 1'b1;
      instruction = 32'hD2B7_DDE3;
      s_start = 1'b1;
      s_instr = 32'hD2B5_79A2;
      ready = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({cw, k, valid, busy, done, illegal} !== '0) begin
         errors++;
         $display("FAIL reset64: got cw=%h k=%h v=%b b=%b d=%b i=%b, expected all 0", cw, k, valid, busy, done, illegal);
      end
      checks++;
      if ({s_cw, s_k, s_valid, s_busy, s_done, s_illegal} !== '0) begin
         errors++;
         $display("FAIL reset32: got cw=%h k=%h v=%b b=%b, expected all 0", s_cw, s_k, s_valid, s_busy);
      end
      reset_n = 1'b1;
      start = 1'b0;
      s_start = 1'b0;
      ready = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || valid !== 1'b0 || s_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_capture: got busy=%b valid=%b busy32=%b, expected 0 0 0", busy, valid, s_busy);
      end
   endtask

   task automatic test_movz();
      exp_q.push_back(mk(2'b01, 5'd3, 5'd31, 5'b00100, 64'h0000_0000_BEEF_0000));
      run_seq("movz_beef", 32'hD2B7_DDE3, 0, 1'b0);
   endtask

   task automatic test_movk_stall();
      exp_q.push_back(mk(2'b00, 5'd5, 5'd5, 5'b00000, 64'hFFFF_0000_FFFF_FFFF));
      exp_q.push_back(mk(2'b01, 5'd5, 5'd5, 5'b00100, 64'h0000_1234_0000_0000));
      run_seq("movk_stall", 32'hF2C2_4685, 3, 1'b0);
   endtask

   task automatic test_movn();
`ifdef WIDE_MOVE_MOVN_EN
      exp_q.push_back(mk(2'b01, 5'd0, 5'd31, 5'b00100, 64'hFFFF_FFFF_FFFF_FFFF));
      run_seq("movn", 32'h9280_0000, 0, 1'b0);
`else
      start = 1'b1;
      instruction = 32'h9280_0000;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (illegal !== 1'b1 || valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL movn_disabled: got illegal=%b valid=%b busy=%b, expected 1 0 0", illegal, valid, busy);
      end
      @(negedge clk);
      checks++;
      if (illegal !== 1'b0 || valid !== 1'b0) begin
         errors++;
         $display("FAIL movn_disabled_after: got illegal=%b valid=%b, expected 0 0", illegal, valid);
      end
`endif
   endtask

   task automatic test_illegal();
      start = 1'b1;
      instruction = 32'hB280_0041;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (illegal !== 1'b1 || busy !== 1'b0 || valid !== 1'b0 || cw !== 31'd0) begin
         errors++;
         $display("FAIL opc01: got illegal=%b busy=%b valid=%b cw=%h, expected 1 0 0 0", illegal, busy, valid, cw);
      end
      @(negedge clk);
      checks++;
      if (illegal !== 1'b0 || busy !== 1'b0 || cw !== 31'd0) begin
         errors++;
         $display("FAIL opc01_pulse: got illegal=%b busy=%b cw=%h, expected 0 0 0", illegal, busy, cw);
      end
   endtask

   task automatic test_width32();
      s_start = 1'b1;
      s_instr = 32'hD2C0_0021;
      @(negedge clk);
      s_start = 1'b0;
      checks++;
      if (s_illegal !== 1'b1 || s_busy !== 1'b0 || s_valid !== 1'b0 || s_cw !== 31'd0) begin
         errors++;
         $display("FAIL w32_hw2: got illegal=%b busy=%b valid=%b cw=%h, expected 1 0 0 0", s_illegal, s_busy, s_valid, s_cw);
      end
      @(negedge clk);
      checks++;
      if (s_illegal !== 1'b0 || s_busy !== 1'b0) begin
         errors++;
         $display("FAIL w32_hw2_pulse: got illegal=%b busy=%b, expected 0 0", s_illegal, s_busy);
      end
      s_start = 1'b1;
      s_instr = 32'hD2B5_79A2;
      @(negedge clk);
      s_start = 1'b0;
      checks++;
      if (s_valid !== 1'b1 || s_cw !== {2'b01, 5'd2, 5'd31, 5'd31, 5'b00100, 9'b100100100} || s_k !== 32'hABCD_0000) begin
         errors++;
         $display("FAIL w32_movz: got valid=%b cw=%h k=%h, expected valid=1 k=abcd0000", s_valid, s_cw, s_k);
      end
      @(negedge clk);
      checks++;
      if (s_done !== 1'b1 || s_valid !== 1'b0) begin
         errors++;
         $display("FAIL w32_done: got done=%b valid=%b, expected 1 0", s_done, s_valid);
      end
   endtask

   task automatic test_reset_mid_seq();
      start = 1'b1;
      instruction = 32'hF2C2_4685;
      ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      ready = 1'b0;
      checks++;
      if ({cw, k} !== mk(2'b01, 5'd5, 5'd5, 5'b00100, 64'h0000_1234_0000_0000)) begin
         errors++;
         $display("FAIL mid_step2: got cw=%h k=%h, expected STEP2 word", cw, k);
      end
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      checks++;
      if ({cw, k, valid, busy, done, illegal} !== '0) begin
         errors++;
         $display("FAIL mid_reset: got cw=%h k=%h v=%b b=%b d=%b, expected all 0", cw, k, valid, busy, done);
      end
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_quiet: got done=%b valid=%b, expected 0 0", done, valid);
         end
      end
      model_push(32'hD2B7_DDE3);
      run_seq("after_reset_movz", 32'hD2B7_DDE3, 1, 1'b0);
   endtask

   task automatic test_start_ignored();
      model_push(32'hF2A0_2466);
      run_seq("start_ignored", 32'hF2A0_2466, 2, 1'b1);
   endtask

   task automatic test_back_to_back();
      logic [31:0] ins;
      logic [1:0]  opc;
      for (int i = 0; i < 8; i++) begin
`ifdef WIDE_MOVE_MOVN_EN
         case ($urandom_range(0, 2))
            0:       opc = 2'b10;
            1:       opc = 2'b11;
            default: opc = 2'b00;
         endcase
`else
         opc = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
`endif
         ins = {1'b1, opc, 6'b100101, 2'($urandom_range(0, 3)), 16'($urandom), 5'($urandom)};
         model_push(ins);
         run_seq("b2b", ins, $urandom_range(0, 2), 1'b0);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      start = 1'b0;
      ready = 1'b0;
      instruction = 32'd0;
      s_start = 1'b0;
      s_instr = 32'd0;
      @(negedge clk);
      test_reset();
      test_movz();
      test_movk_stall();
      test_movn();
      test_illegal();
      test_width32();
      test_reset_mid_seq();
      test_start_ignored();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
